// File: rtl/grf_bypass.sv
// General register file for the single-cycle MIPS datapath: two combinational
// read ports with optional write-to-read forwarding, a commit trace port and a write counter.
module grf_bypass #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [WIDTH-1:0]  WD,
    input  logic [31:0]       PC,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [ADDR_W-1:0] trace_reg,
    output logic [WIDTH-1:0]  trace_data,
    output logic [31:0]       wr_count
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [WIDTH-1:0]  regs_q [NREG];
    logic [WIDTH-1:0]  regs_d [NREG];
    logic              tr_valid_q, tr_valid_d;
    logic [31:0]       tr_pc_q, tr_pc_d;
    logic [ADDR_W-1:0] tr_reg_q, tr_reg_d;
    logic [WIDTH-1:0]  tr_data_q, tr_data_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              wr_en;

    // A write to index 0 is traced but never committed to storage or counted.
    assign wr_en = WE && (A3 != '0);

    always_comb begin
        regs_d     = regs_q;
        tr_valid_d = WE;
        tr_pc_d    = tr_pc_q;
        tr_reg_d   = tr_reg_q;
        tr_data_d  = tr_data_q;
        cnt_d      = cnt_q;
        if (wr_en) begin
            regs_d[A3] = WD;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        if (WE) begin
            tr_pc_d   = PC;
            tr_reg_d  = A3;
            tr_data_d = WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            tr_valid_q <= 1'b0;
            tr_pc_q    <= '0;
            tr_reg_q   <= '0;
            tr_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            regs_q     <= regs_d;
            tr_valid_q <= tr_valid_d;
            tr_pc_q    <= tr_pc_d;
            tr_reg_q   <= tr_reg_d;
            tr_data_q  <= tr_data_d;
            cnt_q      <= cnt_d;
        end
    end

    // Read muxes: register 0 reads zero, same-cycle write forwarded when enabled.
    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs_q[A1];
        RD2 = (A2 == '0) ? '0 : regs_q[A2];
        if (BYPASS && wr_en && (A3 == A1)) begin
            RD1 = WD;
        end
        if (BYPASS && wr_en && (A3 == A2)) begin
            RD2 = WD;
        end
    end

    assign trace_valid = tr_valid_q;
    assign trace_pc    = tr_pc_q;
    assign trace_reg   = tr_reg_q;
    assign trace_data  = tr_data_q;
    assign wr_count    = cnt_q;

endmodule

// File: tb/tb_grf_bypass.sv
// Scoreboard bench for grf_bypass: one bypassing and one non-bypassing instance
// driven in lockstep against a bench-side register-file model.
module tb_grf_bypass;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD, PC;

    logic [31:0] rd1_b, rd2_b, tpc_b, tdata_b, cnt_b;
    logic [31:0] rd1_n, rd2_n, tpc_n, tdata_n, cnt_n;
    logic [4:0]  treg_b, treg_n;
    logic        tv_b, tv_n;

    grf_bypass #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_b), .RD2(rd2_b), .trace_valid(tv_b), .trace_pc(tpc_b),
        .trace_reg(treg_b), .trace_data(tdata_b), .wr_count(cnt_b)
    );

    grf_bypass #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_n), .RD2(rd2_n), .trace_valid(tv_n), .trace_pc(tpc_n),
        .trace_reg(treg_n), .trace_data(tdata_n), .wr_count(cnt_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];
    logic [31:0] m_cnt, m_pc, m_data;
    logic [4:0]  m_reg;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        m_cnt = '0; m_pc = '0; m_reg = '0; m_data = '0;
    endtask

    // One cycle: drive, check reads before the edge, push expected trace, check after.
    task automatic step(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        exp_t e;
        logic [31:0] eb1, eb2;
        WE = we; A1 = a1; A2 = a2; A3 = a3; WD = wd; PC = pc;
        #1;
        eb1 = (we && a3 != 5'd0 && a3 == a1) ? wd : mdl[a1];
        eb2 = (we && a3 != 5'd0 && a3 == a2) ? wd : mdl[a2];
        check("rd1_byp", rd1_b, eb1);
        check("rd2_byp", rd2_b, eb2);
        check("rd1_nobyp", rd1_n, mdl[a1]);
        check("rd2_nobyp", rd2_n, mdl[a2]);
        if (we) begin
            m_pc = pc; m_reg = a3; m_data = wd;
            if (a3 != 5'd0) begin
                mdl[a3] = wd;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
        end
        e.v = we; e.pc = m_pc; e.r = m_reg; e.d = m_data; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("trace_valid", 32'(tv_b), 32'(e.v));
        check("trace_valid_n", 32'(tv_n), 32'(e.v));
        check("trace_pc", tpc_b, e.pc);
        check("trace_reg", 32'(treg_b), 32'(e.r));
        check("trace_data", tdata_b, e.d);
        check("trace_data_n", tdata_n, e.d);
        check("wr_count", cnt_b, e.cnt);
        check("wr_count_n", cnt_n, e.cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        reset = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; PC = '0;
        #12;
        check("rst_count", cnt_b, 32'd0);
        check("rst_valid", 32'(tv_b), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset then read
        step(1'b0, 5'd5, 5'd31, 5'd0, 32'h0, 32'h0);
        // Basic write, then read it back
        step(1'b1, 5'd1, 5'd2, 5'd8, 32'h1234_5678, 32'h0000_3000);
        step(1'b0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0000_3004);
        // Write to $0: traced, not stored, not counted
        step(1'b1, 5'd0, 5'd8, 5'd0, 32'hFFFF_FFFF, 32'h0000_3008);
        step(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        // Bypass on both ports to the same index
        step(1'b1, 5'd0, 5'd0, 5'd9, 32'hAAAA_0000, 32'h0000_3010);
        step(1'b1, 5'd9, 5'd9, 5'd9, 32'h5555_5555, 32'h0000_3014);
        step(1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0);
        // Bypass on one port only, other port reads a different register
        step(1'b1, 5'd8, 5'd17, 5'd17, 32'hDEAD_BEEF, 32'h0000_3018);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom, 32'h4000 + 32'(i * 4));
        end

        // Async reset mid-cycle: reg[3]=7 and count=4 beforehand
        step(1'b1, 5'd0, 5'd0, 5'd3, 32'd7, 32'h5000);
        force dut_b.cnt_q = 32'd3;
        force dut_n.cnt_q = 32'd3;
        #1;
        release dut_b.cnt_q;
        release dut_n.cnt_q;
        m_cnt = 32'd3;
        step(1'b1, 5'd3, 5'd0, 5'd4, 32'd44, 32'h5004);
        check("pre_rst_count", cnt_b, 32'd4);
        WE = 1'b1; A3 = 5'd3; WD = 32'd99; A1 = 5'd3; A2 = 5'd4;
        #1;
        check("pre_rst_reg3", rd1_n, 32'd7);
        reset = 1'b1;
        #1;
        check("mid_rst_reg3", rd1_n, 32'd0);
        check("mid_rst_reg4", rd2_n, 32'd0);
        check("mid_rst_count", cnt_b, 32'd0);
        check("mid_rst_count_n", cnt_n, 32'd0);
        check("mid_rst_valid", 32'(tv_b), 32'd0);
        model_clear();
        @(posedge clk); #1;
        check("rst_edge_reg3", rd1_n, 32'd0);
        check("rst_edge_count", cnt_b, 32'd0);
        check("rst_edge_valid", 32'(tv_n), 32'd0);
        reset = 1'b0;
        step(1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 32'h0);
        step(1'b1, 5'd3, 5'd0, 5'd3, 32'h0000_0123, 32'h6000);

        // Saturation of the write counter
        force dut_b.cnt_q = 32'hFFFF_FFFE;
        force dut_n.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut_b.cnt_q;
        release dut_n.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd1, 5'd3, 5'd1, 32'h100 + 32'(i), 32'h7000 + 32'(i * 4));
        end
        step(1'b0, 5'd1, 5'd1, 5'd0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
